// File: rtl/tm1637_byte_tx.sv
// TM1637 byte engine: start, 8 data bits LSB first, ACK, optional stop.
// Open-drain SCL/SDA; an open bus lets the next byte skip the start.
module tm1637_byte_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       latch,
  input  logic [7:0] data,
  input  logic       stop_bit,
  output logic       busy,
  output logic       scl_en,
  output logic       scl_out,
  output logic       sda_en,
  output logic       sda_out,
  input  logic       sda_in,
  output logic       ack_err
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    HOLD
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic          stop_q;
  logic          busy_q;
  logic          scl_en_q;
  logic          sda_en_q;
  logic          ack_err_q;
  logic          bus_open_q;
  logic          tick;

  assign tick    = busy_q && (cnt_q == CNT_LAST);
  assign busy    = busy_q;
  assign scl_en  = scl_en_q;
  assign sda_en  = sda_en_q;
  assign ack_err = ack_err_q;
  assign scl_out = 1'b0;
  assign sda_out = 1'b0;

  // Quarter divider: parked at zero while idle, wraps every CLK_DIV.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!busy_q || tick) cnt_d = '0;
  end

  // Byte sequencer with registered pin enables.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      data_q     <= 8'h00;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      scl_en_q   <= 1'b0;
      sda_en_q   <= 1'b0;
      ack_err_q  <= 1'b0;
      bus_open_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE, HOLD: begin
          if (latch) begin
            data_q <= data;
            stop_q <= stop_bit;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            qtr_q  <= 2'd0;
            bit_q  <= 3'd0;
            if (bus_open_q) begin
              state_q  <= BIT;
              scl_en_q <= 1'b1;
              sda_en_q <= ~data[0];
            end else begin
              state_q  <= START;
              scl_en_q <= 1'b0;
              sda_en_q <= 1'b1;
            end
          end
        end
        START: begin
          if (tick) begin
            if (qtr_q == 2'd0) begin
              qtr_q    <= 2'd1;
              scl_en_q <= 1'b1;
            end else begin
              state_q  <= BIT;
              qtr_q    <= 2'd0;
              bit_q    <= 3'd0;
              scl_en_q <= 1'b1;
              sda_en_q <= ~data_q[0];
            end
          end
        end
        BIT: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd1) scl_en_q <= 1'b0;
            if (qtr_q == 2'd3) begin
              scl_en_q <= 1'b1;
              if (bit_q == 3'd7) begin
                state_q  <= ACK;
                sda_en_q <= 1'b0;
              end else begin
                bit_q    <= bit_q + 3'd1;
                sda_en_q <= ~data_q[bit_q + 3'd1];
              end
            end
          end
        end
        ACK: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd1) scl_en_q <= 1'b0;
            if (qtr_q == 2'd3) begin
              ack_err_q <= sda_in;
              scl_en_q  <= 1'b1;
              if (stop_q) begin
                state_q  <= STOP;
                sda_en_q <= 1'b1;
              end else begin
                state_q    <= HOLD;
                sda_en_q   <= 1'b0;
                busy_q     <= 1'b0;
                bus_open_q <= 1'b1;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            qtr_q <= qtr_q + 2'd1;
            if (qtr_q == 2'd1) scl_en_q <= 1'b0;
            if (qtr_q == 2'd2) sda_en_q <= 1'b0;
            if (qtr_q == 2'd3) begin
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              bus_open_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
